// File: rtl/exe_stage_mc_if.sv
// ID/EX-to-EXE and EXE-to-MEM signal bundle for the execute stage.
// master drives the ID/EX side and consumes results; slave is the execute stage.
interface exe_stage_mc_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 5
);
  logic              pause;
  logic              in_valid;
  logic [1:0]        fwd_v1_sel;
  logic [1:0]        fwd_v2_sel;
  logic [1:0]        fwd_src2_sel;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] pc;
  logic [1:0]        br_type;
  logic              wb_en_in;
  logic [1:0]        mem_sig_in;
  logic [DEST_W-1:0] dest_in;
  logic [DATA_W-1:0] alu_fwd;
  logic [DATA_W-1:0] wb_fwd;

  logic [DATA_W-1:0] br_addr;
  logic              br_taken;
  logic              stall_req;
  logic              wb_en_out;
  logic [1:0]        mem_sig_out;
  logic [DEST_W-1:0] dest_out;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] alu_res_out;
  logic [DATA_W-1:0] reg2_out;

  modport master (
    output pause, in_valid, fwd_v1_sel, fwd_v2_sel, fwd_src2_sel, exe_cmd, val1, val2, reg2, pc,
           br_type, wb_en_in, mem_sig_in, dest_in, alu_fwd, wb_fwd,
    input  br_addr, br_taken, stall_req, wb_en_out, mem_sig_out, dest_out, pc_out, alu_res_out,
           reg2_out
  );

  modport slave (
    input  pause, in_valid, fwd_v1_sel, fwd_v2_sel, fwd_src2_sel, exe_cmd, val1, val2, reg2, pc,
           br_type, wb_en_in, mem_sig_in, dest_in, alu_fwd, wb_fwd,
    output br_addr, br_taken, stall_req, wb_en_out, mem_sig_out, dest_out, pc_out, alu_res_out,
           reg2_out
  );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage: forwarding, ALU, branch resolution, EXE/MEM register, and an
// iterative shift-add multiplier that stalls upstream while it runs.
module exe_stage_mc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned MUL_EN = 1
) (
  input logic           clk,
  input logic           rst,
  exe_stage_mc_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  localparam logic [3:0] CmdAdd   = 4'b0000;
  localparam logic [3:0] CmdSub   = 4'b0010;
  localparam logic [3:0] CmdMul   = 4'b0011;
  localparam logic [3:0] CmdAnd   = 4'b0100;
  localparam logic [3:0] CmdOr    = 4'b0101;
  localparam logic [3:0] CmdNor   = 4'b0110;
  localparam logic [3:0] CmdXor   = 4'b0111;
  localparam logic [3:0] CmdShl   = 4'b1000;
  localparam logic [3:0] CmdSra   = 4'b1001;
  localparam logic [3:0] CmdSrl   = 4'b1010;
  localparam logic [3:0] CmdMulhu = 4'b1011;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]   v1, v2, s2, alu_res;
  logic [SHAMT_W-1:0]  shamt;
  logic                is_mul, issue, stall_req;

  logic [SHAMT_W-1:0]  cnt_q;
  logic [2*DATA_W-1:0] acc_q, mcand_q;
  logic [DATA_W-1:0]   mplier_q, pc_lq, s2_lq;
  logic                hi_q, wb_lq;
  logic [1:0]          mem_lq;
  logic [DEST_W-1:0]   dest_lq;

  logic                wb_q, wb_d;
  logic [1:0]          mem_q, mem_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   pc_q, pc_d, alu_q, alu_d, r2_q, r2_d;

  // Forwarding muxes; select 11 falls back to the ID value.
  always_comb begin
    v1 = bus.val1;
    v2 = bus.val2;
    s2 = bus.reg2;
    case (bus.fwd_v1_sel)
      2'b01:   v1 = bus.alu_fwd;
      2'b10:   v1 = bus.wb_fwd;
      default: v1 = bus.val1;
    endcase
    case (bus.fwd_v2_sel)
      2'b01:   v2 = bus.alu_fwd;
      2'b10:   v2 = bus.wb_fwd;
      default: v2 = bus.val2;
    endcase
    case (bus.fwd_src2_sel)
      2'b01:   s2 = bus.alu_fwd;
      2'b10:   s2 = bus.wb_fwd;
      default: s2 = bus.reg2;
    endcase
  end

  assign shamt = v2[SHAMT_W-1:0];

  // MUL/MULHU yield 0 here; their real result comes from the multiplier path.
  always_comb begin
    alu_res = '0;
    case (bus.exe_cmd)
      CmdAdd:  alu_res = v1 + v2;
      CmdSub:  alu_res = v1 - v2;
      CmdAnd:  alu_res = v1 & v2;
      CmdOr:   alu_res = v1 | v2;
      CmdNor:  alu_res = ~(v1 | v2);
      CmdXor:  alu_res = v1 ^ v2;
      CmdShl:  alu_res = v1 << shamt;
      CmdSra:  alu_res = $signed(v1) >>> shamt;
      CmdSrl:  alu_res = v1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  assign bus.br_addr = bus.pc + {v2[DATA_W-1:2], 2'b00};

  always_comb begin
    bus.br_taken = 1'b0;
    case (bus.br_type)
      2'b01:   bus.br_taken = (v1 == '0);
      2'b10:   bus.br_taken = (v1 != s2);
      2'b11:   bus.br_taken = 1'b1;
      default: bus.br_taken = 1'b0;
    endcase
    bus.br_taken = bus.br_taken & bus.in_valid;
  end

  assign is_mul = (bus.exe_cmd == CmdMul) || (bus.exe_cmd == CmdMulhu);
  assign issue  = bus.in_valid & is_mul & (MUL_EN != 0) & ~bus.pause;

  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    case (state_q)
      StIdle: begin
        if (issue) begin
          state_d   = StBusy;
          stall_req = 1'b1;
        end
      end
      StBusy: begin
        stall_req = 1'b1;
        if (cnt_q == SHAMT_W'(DATA_W - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.pause) stall_req = 1'b1;
        else           state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.stall_req = stall_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= 1'b0;
      wb_lq    <= 1'b0;
      mem_lq   <= '0;
      dest_lq  <= '0;
      pc_lq    <= '0;
      s2_lq    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && issue) begin
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= {{DATA_W{1'b0}}, v1};
        mplier_q <= v2;
        hi_q     <= (bus.exe_cmd == CmdMulhu);
        wb_lq    <= bus.wb_en_in;
        mem_lq   <= bus.mem_sig_in;
        dest_lq  <= bus.dest_in;
        pc_lq    <= bus.pc;
        s2_lq    <= s2;
      end else if (state_q == StBusy) begin
        // LSB-first: add the shifted multiplicand when the current multiplier bit is set.
        acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHAMT_W'(1);
      end
    end
  end

  always_comb begin
    wb_d   = wb_q;
    mem_d  = mem_q;
    dest_d = dest_q;
    pc_d   = pc_q;
    alu_d  = alu_q;
    r2_d   = r2_q;
    if (!bus.pause) begin
      if (stall_req) begin
        wb_d   = 1'b0;
        mem_d  = '0;
        dest_d = '0;
        pc_d   = '0;
        alu_d  = '0;
        r2_d   = '0;
      end else if (state_q == StDone) begin
        wb_d   = wb_lq;
        mem_d  = mem_lq;
        dest_d = dest_lq;
        pc_d   = pc_lq;
        alu_d  = hi_q ? acc_q[2*DATA_W-1:DATA_W] : acc_q[DATA_W-1:0];
        r2_d   = s2_lq;
      end else begin
        wb_d   = bus.wb_en_in & bus.in_valid;
        mem_d  = bus.in_valid ? bus.mem_sig_in : 2'b00;
        dest_d = bus.dest_in;
        pc_d   = bus.pc;
        alu_d  = alu_res;
        r2_d   = s2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q   <= 1'b0;
      mem_q  <= '0;
      dest_q <= '0;
      pc_q   <= '0;
      alu_q  <= '0;
      r2_q   <= '0;
    end else begin
      wb_q   <= wb_d;
      mem_q  <= mem_d;
      dest_q <= dest_d;
      pc_q   <= pc_d;
      alu_q  <= alu_d;
      r2_q   <= r2_d;
    end
  end

  assign bus.wb_en_out   = wb_q;
  assign bus.mem_sig_out = mem_q;
  assign bus.dest_out    = dest_q;
  assign bus.pc_out      = pc_q;
  assign bus.alu_res_out = alu_q;
  assign bus.reg2_out    = r2_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Scoreboard bench for exe_stage_mc: expected EXE/MEM contents are queued at issue
// and popped when the register is expected to load them.
module tb_exe_stage_mc;
  localparam int unsigned DW  = 32;
  localparam int unsigned DSW = 5;

  localparam logic [3:0] C_ADD = 4'b0000;
  localparam logic [3:0] C_MUL = 4'b0011;
  localparam logic [3:0] C_MULHU = 4'b1011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_mc_if #(.DATA_W(DW), .DEST_W(DSW)) bus ();
  exe_stage_mc #(.DATA_W(DW), .DEST_W(DSW), .MUL_EN(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] alu;
    logic        wb;
    logic [1:0]  mem;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] r2;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  function automatic exp_t make_exp(input logic [31:0] alu, input logic wb, input logic [1:0] mem,
                                    input logic [4:0] dest, input logic [31:0] pc,
                                    input logic [31:0] r2);
    exp_t e;
    e.alu = alu; e.wb = wb; e.mem = mem; e.dest = dest; e.pc = pc; e.r2 = r2;
    return e;
  endfunction

  function automatic exp_t observed();
    return make_exp(bus.alu_res_out, bus.wb_en_out, bus.mem_sig_out, bus.dest_out, bus.pc_out,
                    bus.reg2_out);
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a | b);
      4'b0111: r = a ^ b;
      4'b1000: r = a << b[4:0];
      4'b1001: r = $signed(a) >>> b[4:0];
      4'b1010: r = a >> b[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r2, input logic [31:0] pcv,
                       input logic wb, input logic [1:0] mem, input logic [4:0] dest);
    bus.in_valid = v;   bus.exe_cmd = cmd;  bus.val1 = a;        bus.val2 = b;
    bus.reg2 = r2;      bus.pc = pcv;       bus.wb_en_in = wb;   bus.mem_sig_in = mem;
    bus.dest_in = dest; bus.br_type = 2'b00;
    bus.fwd_v1_sel = 2'b00; bus.fwd_v2_sel = 2'b00; bus.fwd_src2_sel = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, C_ADD, 32'd5, 32'd3, 32'd1, 32'd4, 1'b1, 2'b11, 5'd7);
    tick;
    tick;
    total++;
    if (observed() !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_req);
    end
    rst = 1'b0;
    drive(1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 5'd0);
  endtask

  task automatic test_add;
    exp_t e;
    drive(1'b1, C_ADD, 32'd5, 32'd3, 32'd11, 32'd100, 1'b1, 2'b00, 5'd4);
    sbq.push_back(make_exp(32'd8, 1'b1, 2'b00, 5'd4, 32'd100, 32'd11));
    #1;
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL add_stall: got %b want 0", bus.stall_req);
    end
    tick;
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL add_out: got %h want %h", observed(), e);
    end
    // Wraparound at the top of the range.
    drive(1'b1, C_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd104, 1'b1, 2'b01, 5'd5);
    sbq.push_back(make_exp(32'd1, 1'b1, 2'b01, 5'd5, 32'd104, 32'd0));
    tick;
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL add_wrap: got %h want %h", observed(), e);
    end
  endtask

  task automatic test_alu_ops;
    logic [3:0]  cmds [11] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd1, 4'd12, 4'd15};
    logic [31:0] a, b;
    logic        v;
    exp_t        e;
    for (int i = 0; i < 11; i++) begin
      a = $urandom;
      b = $urandom;
      if (cmds[i] == 4'd9) a[31] = 1'b1;
      v = (i % 4) != 3;
      drive(v, cmds[i], a, b, ~a, 32'h40 + 32'(i), 1'b1, 2'(i), 5'(i + 1));
      sbq.push_back(make_exp(alu_model(cmds[i], a, b), v, v ? 2'(i) : 2'b00, 5'(i + 1),
                             32'h40 + 32'(i), ~a));
      tick;
      e = sbq.pop_front();
      total++;
      if (observed() !== e) begin
        bad++; $display("FAIL alu_cmd%0d: got %h want %h", cmds[i], observed(), e);
      end
    end
  endtask

  task automatic test_fwd_branch;
    exp_t e;
    drive(1'b1, C_ADD, 32'h55, 32'h1237, 32'd9, 32'h1000, 1'b1, 2'b10, 5'd12);
    bus.fwd_v1_sel = 2'b01; bus.alu_fwd = 32'd9; bus.wb_fwd = 32'h40; bus.br_type = 2'b10;
    #1;
    total++;
    if (bus.br_taken !== 1'b0) begin
      bad++; $display("FAIL bne_equal: got %b want 0", bus.br_taken);
    end
    bus.reg2 = 32'd8;
    #1;
    total++;
    if (bus.br_taken !== 1'b1) begin
      bad++; $display("FAIL bne_differ: got %b want 1", bus.br_taken);
    end
    total++;
    if (bus.br_addr !== 32'h2234) begin
      bad++; $display("FAIL br_addr: got %h want %h", bus.br_addr, 32'h2234);
    end
    sbq.push_back(make_exp(32'd9 + 32'h1237, 1'b1, 2'b10, 5'd12, 32'h1000, 32'd8));
    tick;
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL fwd_out: got %h want %h", observed(), e);
    end
    bus.fwd_src2_sel = 2'b10; bus.wb_fwd = 32'd9;
    #1;
    total++;
    if (bus.br_taken !== 1'b0) begin
      bad++; $display("FAIL bne_fwd_src2: got %b want 0", bus.br_taken);
    end
    bus.fwd_v1_sel = 2'b11; bus.val1 = 32'd0; bus.br_type = 2'b01;
    #1;
    total++;
    if (bus.br_taken !== 1'b1) begin
      bad++; $display("FAIL bez_sel11: got %b want 1", bus.br_taken);
    end
    bus.fwd_v2_sel = 2'b10; bus.wb_fwd = 32'h43; bus.br_type = 2'b11;
    #1;
    total++;
    if (bus.br_taken !== 1'b1 || bus.br_addr !== 32'h1040) begin
      bad++; $display("FAIL jmp_fwd_v2: got %b/%h want 1/%h", bus.br_taken, bus.br_addr, 32'h1040);
    end
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.br_taken !== 1'b0) begin
      bad++; $display("FAIL jmp_invalid: got %b want 0", bus.br_taken);
    end
    bus.in_valid = 1'b1; bus.br_type = 2'b00;
    #1;
    total++;
    if (bus.br_taken !== 1'b0) begin
      bad++; $display("FAIL br_none: got %b want 0", bus.br_taken);
    end
    drive(1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 5'd0);
    tick;
  endtask

  task automatic test_mul;
    int   stalls = 0;
    exp_t e;
    drive(1'b1, C_MUL, 32'h1234, 32'd6, 32'hAB, 32'h300, 1'b1, 2'b10, 5'd9);
    bus.fwd_v1_sel = 2'b10; bus.wb_fwd = 32'd7;
    sbq.push_back(make_exp(32'd42, 1'b1, 2'b10, 5'd9, 32'h300, 32'hAB));
    #1;
    while (bus.stall_req === 1'b1 && stalls < 100) begin
      if (stalls > 0) begin
        total++;
        if (bus.wb_en_out !== 1'b0 || bus.mem_sig_out !== 2'b00 || bus.dest_out !== 5'd0) begin
          bad++; $display("FAIL mul_bubble%0d: got %b/%b/%0d want 0/0/0", stalls,
                          bus.wb_en_out, bus.mem_sig_out, bus.dest_out);
        end
      end
      stalls++;
      if (stalls == 5) bus.wb_fwd = 32'd100;
      tick;
    end
    total++;
    if (stalls != 33) begin
      bad++; $display("FAIL mul_stall_len: got %0d want 33", stalls);
    end
    tick;
    drive(1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 5'd0);
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL mul_result: got %h want %h", observed(), e);
    end
    #1;
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL mul_no_reissue: got %b want 0", bus.stall_req);
    end
  endtask

  task automatic mul_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest);
    int              stalls = 0;
    logic [63:0]     prod;
    exp_t            e;
    prod = 64'(a) * 64'(b);
    drive(1'b1, cmd, a, b, 32'h5A, 32'h800, 1'b1, 2'b01, dest);
    sbq.push_back(make_exp(cmd == C_MULHU ? prod[63:32] : prod[31:0], 1'b1, 2'b01, dest,
                           32'h800, 32'h5A));
    #1;
    while (bus.stall_req === 1'b1 && stalls < 100) begin
      stalls++;
      tick;
    end
    total++;
    if (stalls != 33) begin
      bad++; $display("FAIL mul_op%0d_stall_len: got %0d want 33", cmd, stalls);
    end
    tick;
    drive(1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 5'd0);
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL mul_op%0d_result: got %h want %h", cmd, observed(), e);
    end
  endtask

  task automatic test_mulhu;
    mul_op(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    mul_op(C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    mul_op(C_MULHU, 32'h8000_0001, 32'h0001_0003, 5'd13);
  endtask

  task automatic test_pause;
    exp_t e, held;
    drive(1'b1, C_MUL, 32'd7, 32'd6, 32'h77, 32'h200, 1'b1, 2'b11, 5'd3);
    sbq.push_back(make_exp(32'd42, 1'b1, 2'b11, 5'd3, 32'h200, 32'h77));
    for (int i = 0; i < 10; i++) tick;
    bus.pause = 1'b1;
    for (int i = 0; i < 28; i++) begin
      tick;
      total++;
      if (bus.stall_req !== 1'b1 || observed() !== '0) begin
        bad++; $display("FAIL pause_frozen%0d: got %b/%h want 1/0", i, bus.stall_req, observed());
      end
    end
    bus.pause = 1'b0;
    #1;
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL pause_release_stall: got %b want 0", bus.stall_req);
    end
    tick;
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL pause_mul_result: got %h want %h", observed(), e);
    end
    drive(1'b1, C_ADD, 32'd1, 32'd1, 32'd0, 32'h210, 1'b1, 2'b00, 5'd7);
    sbq.push_back(make_exp(32'd2, 1'b1, 2'b00, 5'd7, 32'h210, 32'd0));
    tick;
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL after_mul_add: got %h want %h", observed(), e);
    end
    drive(1'b1, C_ADD, 32'd10, 32'd20, 32'd2, 32'h220, 1'b1, 2'b01, 5'd5);
    held = make_exp(32'd30, 1'b1, 2'b01, 5'd5, 32'h220, 32'd2);
    tick;
    drive(1'b1, C_ADD, 32'd3, 32'd4, 32'd6, 32'h224, 1'b1, 2'b10, 5'd6);
    bus.pause = 1'b1;
    tick;
    tick;
    total++;
    if (observed() !== held) begin
      bad++; $display("FAIL pause_add_hold: got %h want %h", observed(), held);
    end
    bus.pause = 1'b0;
    sbq.push_back(make_exp(32'd7, 1'b1, 2'b10, 5'd6, 32'h224, 32'd6));
    tick;
    e = sbq.pop_front();
    total++;
    if (observed() !== e) begin
      bad++; $display("FAIL pause_add_resume: got %h want %h", observed(), e);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    drive(1'b1, C_MUL, 32'h1234, 32'h55, 32'd1, 32'h300, 1'b1, 2'b01, 5'd8);
    for (int i = 0; i < 15; i++) tick;
    rst = 1'b1;
    drive(1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 5'd0);
    tick;
    rst = 1'b0;
    total++;
    if (bus.stall_req !== 1'b0 || observed() !== '0) begin
      bad++; $display("FAIL rst_mid: got %b/%h want 0/0", bus.stall_req, observed());
    end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.stall_req !== 1'b0 || bus.wb_en_out !== 1'b0 || bus.alu_res_out !== '0) begin
        total++; bad++;
        $display("FAIL rst_mid_ghost%0d: got %b/%b/%h want 0/0/0", i, bus.stall_req,
                 bus.wb_en_out, bus.alu_res_out);
      end
    end
    total++;
    drive(1'b1, C_ADD, 32'd2, 32'd2, 32'd0, 32'h400, 1'b1, 2'b00, 5'd2);
    sbq.push_back(make_exp(32'd4, 1'b1, 2'b00, 5'd2, 32'h400, 32'd0));
    tick;
    e = sbq.pop_front();
    if (observed() !== e) begin
      bad++; $display("FAIL rst_mid_add: got %h want %h", observed(), e);
    end
  endtask

  initial begin
    bus.pause = 1'b0;
    bus.alu_fwd = '0;
    bus.wb_fwd = '0;
    test_reset();
    test_add();
    test_alu_ops();
    test_fwd_branch();
    test_mul();
    test_mulhu();
    test_pause();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
- Parametrised execute stage: operand forwarding, single-cycle ALU, branch target/condition logic, EXE/MEM pipeline register with memory-side pause.
- Adds an iterative unsigned shift-add multiplier (MUL low half, MULHU high half) that stalls upstream stages while it runs.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- DATA_W, 32, datapath width; power of two, minimum 8. Derived localparam SHAMT_W = clog2(DATA_W).
- DEST_W, 5, destination register index width.
- MUL_EN, 1, 1 enables the multiplier; 0 makes MUL/MULHU single-cycle with result 0 and no stall.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pause  in  1  memory stall; freezes output register.
- in_valid  in  1  ID/EX holds a real instruction.
- fwd_v1_sel, fwd_v2_sel, fwd_src2_sel  in  2 each  forwarding selects: 00 ID value, 01 alu_fwd, 10 wb_fwd, 11 ID value.
- exe_cmd  in  4  operation.
- val1, val2, reg2, pc  in  DATA_W each  operands and PC.
- br_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
- wb_en_in  in  1; mem_sig_in  in  2; dest_in  in  DEST_W  control passed to MEM.
- alu_fwd, wb_fwd  in  DATA_W each  forwarded results.
- br_addr  out  DATA_W  pc + {v2[DATA_W-1:2],2'b00}, using forwarded v2.
- br_taken  out  1  branch decision.
- stall_req  out  1  upstream must hold its register.
- wb_en_out  out  1; mem_sig_out  out  2; dest_out  out  DEST_W; pc_out, alu_res_out, reg2_out  out  DATA_W  EXE/MEM register.

Behaviour:
- Forwarding: v1, v2, s2 are 3:1 muxes as above. Select 11 selects the ID value, never X.
- ALU (combinational, on v1/v2):
  - 0000 add; 0010 sub; 0100 and; 0101 or; 0110 nor; 0111 xor.
  - 1000 shl; 1001 arithmetic shr; 1010 logical shr. Shift amount = v2[SHAMT_W-1:0].
  - 0011 MUL; 1011 MULHU.
  - Any other code gives result 0.
  - Add/sub wrap modulo 2^DATA_W.
- Condition (gated by in_valid, uses v1 and s2):
  - BEZ taken when v1==0.
  - BNE taken when v1!=s2.
  - JMP always taken.
  - br_taken=0 when in_valid=0 or br_type=00.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - issue = in_valid & (exe_cmd is MUL or MULHU) & MUL_EN & ~pause.
  - On issue: latch v1, v2, exe_cmd, wb_en_in, mem_sig_in, dest_in, pc, s2. Clear the 2*DATA_W accumulator and the counter. Go to BUSY.
- BUSY:
  - One shift-add step per cycle, LSB of multiplier first.
  - Counter increments; after DATA_W steps go to DONE.
  - BUSY steps continue while pause=1.
- DONE:
  - When pause=0: output register loads the latched control fields and the product half (low for MUL, high for MULHU). Go to IDLE.
  - When pause=1: stay in DONE.
  - The FSM must not re-issue from the held MUL seen in DONE.
- stall_req = (IDLE & issue) | BUSY | (DONE & pause). It is combinational.
- Output register, priority order:
  1. rst: all outputs 0.
  2. pause=1 while not completing a multiply: hold.
  3. stall_req=1: load a bubble (wb_en_out=0, mem_sig_out=0, dest_out=0; data fields don't-care, implemented as 0).
  4. DONE & ~pause: load the multiply result.
  5. Otherwise: load ID fields, alu_res_out = ALU result, reg2_out = s2, pc_out = pc. When in_valid=0, load wb_en_out=0 and mem_sig_out=0.
- Multiply latency: issue cycle plus DATA_W BUSY cycles give DATA_W+1 cycles with stall_req=1. The result is registered at the end of the DONE cycle, DATA_W+2 edges after issue.
- Reset mid-multiply: FSM goes to IDLE, counter and accumulator clear, stall_req=0 in the next cycle, and no result is written.
- MUL_EN=0: FSM stays in IDLE and MUL/MULHU behave as the default code (result 0).

Test Plan:
- Reset, then add: val1=5, val2=3, cmd 0000, wb_en_in=1, dest_in=4 -> after 1 edge alu_res_out=8, wb_en_out=1, dest_out=4. stall_req stays 0.
- Forwarding and BNE: fwd_v1_sel=01, alu_fwd=9, reg2=9, br_type=10 -> br_taken=0. Set reg2=8 -> br_taken=1, br_addr = pc + (val2 & ~3).
- MUL, DATA_W=32: 7*6 with ID inputs held while stall_req=1 -> stall_req high exactly 33 cycles, bubble outputs meanwhile, then alu_res_out=42 with latched dest. Change wb_fwd mid-run -> result unaffected.
- MULHU: 0xFFFFFFFF*0xFFFFFFFF -> alu_res_out=0xFFFFFFFE. Same operands with MUL -> 0x00000001.
- Pause: hold pause=1 from the BUSY cycle 10 through 5 cycles past DONE -> outputs frozen, stall_req high until pause drops, then result 42 loads once. Pause on a plain add -> outputs hold the prior values.
- Assert rst at BUSY cycle 15 -> next cycle stall_req=0, all outputs 0. A following add completes normally.
